// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX write-back stage.
package dlx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ALU  = 2'd1,
    LOAD = 2'd2,
    LINK = 2'd3
  } wb_kind_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  localparam logic [4:0]  LINK_REG    = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/dlx_load_align.sv
// Big-endian lane select and zero/sign extension of data-memory read data.
module dlx_load_align
  import dlx_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    value     = 32'h0000_0000;

    // Offset 0 addresses the most significant byte.
    case (offset)
      2'd0:    byte_lane = data[31:24];
      2'd1:    byte_lane = data[23:16];
      2'd2:    byte_lane = data[15:8];
      default: byte_lane = data[7:0];
    endcase

    half_lane = offset[1] ? data[15:0] : data[31:16];

    case (size)
      BYTE:    value = {{24{is_signed & byte_lane[7]}}, byte_lane};
      HALF:    value = {{16{is_signed & half_lane[15]}}, half_lane};
      default: value = data;
    endcase
  end

endmodule

// File: rtl/dlx_writeback.sv
// DLX write-back stage: register-file write port, load wait with timeout.
// Optional feature macro: DLX_WB_LINK_EN (LINK writes pc+8 to r31).
module dlx_writeback
  import dlx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [1:0]  m_kind,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_result,
  input  logic [31:0] m_pc,
  input  logic [1:0]  m_size,
  input  logic        m_signed,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        WB,
  output logic [4:0]  Rd,
  output logic [31:0] reg_s,
  output logic        load_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Handshake: an instruction transfers when m_valid & m_ready on a rising
  // edge; m_ready depends only on state, never on m_valid.
  wb_state_e   state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_signed_q, ld_signed_d;
  logic        err_q, err_d;
  logic        wb_q, wb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] reg_s_q, reg_s_d;

  logic        accept;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] load_value;

  dlx_load_align u_align (
    .data      (dm_rdata),
    .offset    (ld_off_q),
    .size      (ld_size_q),
    .is_signed (ld_signed_q),
    .value     (load_value)
  );

`ifndef DLX_WB_LINK_EN
  logic unused_pc;
  assign unused_pc = ^m_pc;
`endif

  assign accept = m_valid & (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rd_d     = ld_rd_q;
    ld_off_d    = ld_off_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_rd       = 5'd0;
    wr_data     = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (m_kind)
            ALU: begin
              wr_en   = 1'b1;
              wr_rd   = m_rd;
              wr_data = m_result;
            end
            LINK: begin
              wr_en = 1'b1;
`ifdef DLX_WB_LINK_EN
              wr_rd   = LINK_REG;
              wr_data = m_pc + LINK_OFFSET;
`else
              wr_rd   = m_rd;
              wr_data = m_result;
`endif
            end
            LOAD: begin
              ld_rd_d     = m_rd;
              ld_off_d    = m_result[1:0];
              ld_size_d   = m_size;
              ld_signed_d = m_signed;
              cnt_d       = '0;
              state_d     = ST_WAIT;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        // Response beats the timeout when both land on the same cycle.
        if (dm_rvalid) begin
          wr_en   = 1'b1;
          wr_rd   = ld_rd_q;
          wr_data = load_value;
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // r0 writes are dropped and idle outputs held at zero for the bypass.
    wb_d    = wr_en & (wr_rd != 5'd0);
    rd_d    = wb_d ? wr_rd : 5'd0;
    reg_s_d = wb_d ? wr_data : 32'h0000_0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ld_rd_q     <= 5'd0;
      ld_off_q    <= 2'd0;
      ld_size_q   <= 2'd0;
      ld_signed_q <= 1'b0;
      err_q       <= 1'b0;
      wb_q        <= 1'b0;
      rd_q        <= 5'd0;
      reg_s_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rd_q     <= ld_rd_d;
      ld_off_q    <= ld_off_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      err_q       <= err_d;
      wb_q        <= wb_d;
      rd_q        <= rd_d;
      reg_s_q     <= reg_s_d;
    end
  end

  assign m_ready  = (state_q == ST_IDLE);
  assign WB       = wb_q;
  assign Rd       = rd_q;
  assign reg_s    = reg_s_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_dlx_writeback.sv
// Self-checking bench for dlx_writeback with a short load timeout.
module tb_dlx_writeback;
  import dlx_pkg::*;

  localparam int TO = 4;
`ifdef DLX_WB_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [1:0]  m_kind = 2'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [1:0]  m_size = 2'd0;
  logic        m_signed = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        WB;
  logic [4:0]  Rd;
  logic [31:0] reg_s;
  logic        load_err;

  always #5 clk = ~clk;

  dlx_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready),
    .m_kind(m_kind), .m_rd(m_rd), .m_result(m_result), .m_pc(m_pc),
    .m_size(m_size), .m_signed(m_signed), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .WB(WB), .Rd(Rd), .reg_s(reg_s), .load_err(load_err)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic exp_err = 1'b0;
  logic [37:0] exp_q[$];

  // Reference: pick nb bytes starting pos bytes from the MSB, then extend.
  function automatic logic [31:0] ref_load(logic [31:0] data, logic [1:0] off,
                                           logic [1:0] size, logic sgn);
    int nb, pos;
    logic [63:0] v, mask;
    case (size)
      2'd0:    begin nb = 1; pos = int'(off); end
      2'd1:    begin nb = 2; pos = (off >= 2'd2) ? 2 : 0; end
      default: begin nb = 4; pos = 0; end
    endcase
    v    = 64'(data) >> (8 * (4 - pos - nb));
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (sgn && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Expected {WB, Rd, reg_s} one cycle after accepting a non-load instruction.
  function automatic logic [37:0] ref_write(logic [1:0] kind, logic [4:0] rd,
                                            logic [31:0] res, logic [31:0] pc);
    if (kind == LINK && LINK_EN) return {1'b1, 5'd31, pc + 32'd8};
    if ((kind == ALU || kind == LINK) && rd != 5'd0) return {1'b1, rd, res};
    return 38'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_valid = 1'b0; m_kind = 2'd0; m_rd = 5'd0; m_result = 32'd0;
    m_pc = 32'd0; m_size = 2'd0; m_signed = 1'b0;
    dm_rvalid = 1'b0; dm_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if ({WB, Rd, reg_s, load_err, m_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got WB=%b Rd=%0d reg_s=%h err=%b rdy=%b want 0 0 0 0 1",
               WB, Rd, reg_s, load_err, m_ready);
    end
    step();
  endtask

  task automatic test_alu();
    m_valid = 1'b1; m_kind = ALU; m_rd = 5'd5; m_result = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    checks++;
    if ({WB, Rd, reg_s} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL alu_write: got WB=%b Rd=%0d reg_s=%h want 1 5 deadbeef", WB, Rd, reg_s);
    end
    step();
    checks++;
    if ({WB, Rd, reg_s} !== 38'd0) begin
      errors++;
      $display("FAIL alu_idle: got WB=%b Rd=%0d reg_s=%h want 0 0 0", WB, Rd, reg_s);
    end
    m_valid = 1'b1; m_kind = ALU; m_rd = 5'd0; m_result = 32'h55;
    for (int i = 0; i < 2; i++) begin
      step();
      idle_inputs();
      checks++;
      if ({WB, Rd, reg_s} !== 38'd0) begin
        errors++;
        $display("FAIL alu_r0 cycle %0d: got WB=%b Rd=%0d reg_s=%h want 0 0 0", i, WB, Rd, reg_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp;
    for (int i = 0; i < 40; i++) begin
      m_valid   = ($urandom_range(0, 4) != 0);
      m_kind    = 2'($urandom_range(0, 3));
      if (m_kind == LOAD) m_kind = ALU;
      m_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      m_result  = $urandom;
      m_pc      = $urandom;
      dm_rvalid = $urandom_range(0, 1);
      dm_rdata  = $urandom;
      exp_q.push_back(m_valid ? ref_write(m_kind, m_rd, m_result, m_pc) : 38'd0);
      step();
      exp = exp_q.pop_front();
      checks++;
      if ({WB, Rd, reg_s} !== exp || m_ready !== 1'b1 || load_err !== exp_err) begin
        errors++;
        $display("FAIL b2b[%0d]: got WB=%b Rd=%0d reg_s=%h rdy=%b err=%b want WB=%b Rd=%0d reg_s=%h rdy=1 err=%b",
                 i, WB, Rd, reg_s, m_ready, load_err, exp[37], exp[36:32], exp[31:0], exp_err);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [1:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] data, input int delay,
                         input logic [31:0] exp_val);
    logic [37:0] exp;
    m_valid = 1'b1; m_kind = LOAD; m_rd = rd; m_result = {30'($urandom), addr};
    m_size = size; m_signed = sgn; dm_rvalid = 1'b0;
    step();
    // Keep presenting an ALU op during the stall; it must not be taken.
    m_kind = ALU; m_rd = 5'd3; m_result = $urandom;
    checks++;
    if (m_ready !== 1'b0 || WB !== 1'b0) begin
      errors++;
      $display("FAIL load_accept: got rdy=%b WB=%b want 0 0", m_ready, WB);
    end
    for (int i = 1; i < delay; i++) begin
      step();
      checks++;
      if (m_ready !== 1'b0 || WB !== 1'b0) begin
        errors++;
        $display("FAIL load_stall[%0d]: got rdy=%b WB=%b want 0 0", i, m_ready, WB);
      end
    end
    dm_rvalid = 1'b1; dm_rdata = data; m_valid = 1'b0;
    step();
    dm_rvalid = 1'b0; dm_rdata = $urandom;
    exp = (rd != 5'd0) ? {1'b1, rd, exp_val} : 38'd0;
    checks++;
    if ({WB, Rd, reg_s} !== exp || m_ready !== 1'b1 || load_err !== exp_err) begin
      errors++;
      $display("FAIL load_write: got WB=%b Rd=%0d reg_s=%h rdy=%b err=%b want WB=%b Rd=%0d reg_s=%h rdy=1 err=%b",
               WB, Rd, reg_s, m_ready, load_err, exp[37], exp[36:32], exp[31:0], exp_err);
    end
    step();
    checks++;
    if ({WB, Rd, reg_s} !== 38'd0) begin
      errors++;
      $display("FAIL load_after: got WB=%b Rd=%0d reg_s=%h want 0 0 0", WB, Rd, reg_s);
    end
    idle_inputs();
  endtask

  task automatic test_load();
    logic [1:0]  a, sz;
    logic        sg;
    logic [31:0] d;
    logic [4:0]  rd;
    do_load(5'd8, 2'd1, BYTE, 1'b1, 32'h1280_3456, 3, 32'hFFFF_FF80);
    do_load(5'd9, 2'd2, HALF, 1'b0, 32'h1234_ABCD, 1, 32'h0000_ABCD);
    do_load(5'd9, 2'd2, HALF, 1'b1, 32'h1234_ABCD, 2, 32'hFFFF_ABCD);
    do_load(5'd10, 2'd3, WORD, 1'b1, 32'h8765_4321, TO, 32'h8765_4321);
    for (int i = 0; i < 24; i++) begin
      a  = 2'($urandom);
      sz = 2'($urandom_range(0, 2));
      sg = $urandom_range(0, 1);
      d  = $urandom;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      do_load(rd, a, sz, sg, d, $urandom_range(1, TO), ref_load(d, a, sz, sg));
    end
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_kind = LOAD; m_rd = 5'd7; m_result = 32'h1000; m_size = WORD;
    step();
    idle_inputs();
    for (int i = 1; i <= TO; i++) begin
      step();
      checks++;
      if (i < TO) begin
        if (m_ready !== 1'b0 || load_err !== 1'b0 || WB !== 1'b0) begin
          errors++;
          $display("FAIL timeout_wait[%0d]: got rdy=%b err=%b WB=%b want 0 0 0", i, m_ready, load_err, WB);
        end
      end else begin
        if (m_ready !== 1'b1 || load_err !== 1'b1 || WB !== 1'b0) begin
          errors++;
          $display("FAIL timeout_fire: got rdy=%b err=%b WB=%b want 1 1 0", m_ready, load_err, WB);
        end
      end
    end
    exp_err = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    step();
    dm_rvalid = 1'b0;
    checks++;
    if (WB !== 1'b0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_late: got WB=%b err=%b want 0 1", WB, load_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    m_valid = 1'b1; m_kind = LOAD; m_rd = 5'd12; m_result = 32'h2000; m_size = WORD;
    step();
    idle_inputs();
    step();
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    checks++;
    if ({WB, Rd, reg_s, load_err, m_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_wait: got WB=%b Rd=%0d reg_s=%h err=%b rdy=%b want 0 0 0 0 1",
               WB, Rd, reg_s, load_err, m_ready);
    end
    #2 rst_n = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222;
    step();
    dm_rvalid = 1'b0;
    checks++;
    if ({WB, Rd, reg_s} !== 38'd0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_late_rvalid: got WB=%b Rd=%0d reg_s=%h rdy=%b want 0 0 0 1", WB, Rd, reg_s, m_ready);
    end
  endtask

  task automatic test_link();
    logic [37:0] exp;
    m_valid = 1'b1; m_kind = LINK; m_rd = 5'd9; m_result = 32'h1234; m_pc = 32'h100;
    step();
    idle_inputs();
    exp = LINK_EN ? {1'b1, 5'd31, 32'h108} : {1'b1, 5'd9, 32'h1234};
    checks++;
    if ({WB, Rd, reg_s} !== exp) begin
      errors++;
      $display("FAIL link: got WB=%b Rd=%0d reg_s=%h want WB=%b Rd=%0d reg_s=%h",
               WB, Rd, reg_s, exp[37], exp[36:32], exp[31:0]);
    end
    m_valid = 1'b1; m_kind = LINK; m_rd = 5'd0; m_result = 32'h77; m_pc = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    exp = LINK_EN ? {1'b1, 5'd31, 32'h4} : 38'd0;
    checks++;
    if ({WB, Rd, reg_s} !== exp) begin
      errors++;
      $display("FAIL link_wrap: got WB=%b Rd=%0d reg_s=%h want WB=%b Rd=%0d reg_s=%h",
               WB, Rd, reg_s, exp[37], exp[36:32], exp[31:0]);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_link();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dlx_writeback.md
# dlx_writeback

Write-back stage of the DLX pipeline: accepts retiring instructions from the memory stage and drives the register-file write port (`WB`, `Rd`, `reg_s`). It retires ALU results in one cycle. For loads it waits on the data-memory read response, then aligns and extends the data before the write. It owns the only write path into the register file and the load-wait stall back into the pipeline.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before a load is abandoned (must be ≥ 2).
- `TO_W`, `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `m_valid`  in  1  memory stage presents an instruction.
- `m_ready`  out  1  stage can accept; low = pipeline stall.
- `m_kind`  in  2  `wb_kind_e`: NONE, ALU, LOAD, LINK.
- `m_rd`  in  5  destination register number.
- `m_result`  in  32  ALU result; for LOAD, the byte address.
- `m_pc`  in  32  instruction PC (used by LINK).
- `m_size`  in  2  `mem_size_e`: BYTE, HALF, WORD.
- `m_signed`  in  1  sign-extend load data.
- `dm_rvalid`  in  1  data-memory read data valid.
- `dm_rdata`  in  32  data-memory read data, big-endian.
- `WB`  out  1  register-file write enable, one-cycle pulse.
- `Rd`  out  5  register-file write register number.
- `reg_s`  out  32  register-file write data.
- `load_err`  out  1  sticky: a load timed out.

## Operation
- FSM states: IDLE, WAIT. Reset state is IDLE. `m_ready` = (state == IDLE).
- Accept = `m_valid & m_ready`.
- IDLE + accept:
  - ALU: next cycle `WB`=1, `Rd`=`m_rd`, `reg_s`=`m_result`. Stay in IDLE.
  - NONE: no write. Stay in IDLE.
  - LOAD: latch `m_rd`, `m_result[1:0]`, `m_size` and `m_signed`. Clear the timeout counter. Go to WAIT.
- WAIT + `dm_rvalid`: next cycle write the aligned data to the latched rd, then return to IDLE.
- WAIT without `dm_rvalid`: the counter increments. When it reaches `TIMEOUT_CYCLES`, set `load_err`, perform no write, and return to IDLE.
- Any write with rd == 0 is suppressed: `WB` stays 0 and the outputs remain idle.
- Idle outputs: when `WB`=0, `Rd`=0 and `reg_s`=0. The register file's bypass compares `Rd` independently of `WB`, so this keeps r0 reads correct.
- Load alignment uses big-endian byte lanes, with off = addr[1:0]:
  - BYTE: `dm_rdata[31-8*off -: 8]`.
  - HALF: off[1]=0 gives [31:16], off[1]=1 gives [15:0]; off[0] is ignored.
  - WORD: all 32 bits; off is ignored.
- Extension: zero-extend when `m_signed`=0, sign-extend otherwise.
- `dm_rvalid` in IDLE is ignored.
- `load_err` clears only on reset.

## Timing
- Reset values: `WB`=0, `Rd`=0, `reg_s`=0, `load_err`=0, `m_ready`=1, state IDLE, counter 0.
- `WB`, `Rd` and `reg_s` are registered.
- ALU and LINK latency is 1 cycle from accept. Back-to-back ALU accepts give back-to-back `WB` pulses.
- Load: earliest `dm_rvalid` is the cycle after accept. The write occurs the cycle after `dm_rvalid`. `m_ready` is low from the cycle after accept through the `dm_rvalid` cycle and rises the cycle after.
- Timeout: with no response, `load_err` rises and `m_ready` returns to 1 exactly `TIMEOUT_CYCLES` cycles after entering WAIT.
- `dm_rvalid` arriving in the same cycle the counter reaches the limit: the data wins; write, no error.
- Reset mid-WAIT: the pending load is dropped with no write. A late `dm_rvalid` after reset is ignored.

## Configuration
- `DLX_WB_LINK_EN`:
  - Defined: LINK writes `m_pc + 8` (modulo 2^32) to r31, ignoring `m_rd`. Latency is the same as ALU.
  - Undefined: LINK is handled exactly as ALU, writing `m_result` to `m_rd`.

## Structure
- Package `dlx_pkg`: `wb_kind_e`, `mem_size_e`, `LINK_REG` = 5'd31, `LINK_OFFSET` = 32'd8.
- Sub-module `dlx_load_align`: combinational; inputs data, offset, size and signed; output 32-bit value.
- FSM, counter and output registers stay in `dlx_writeback`.

## Test plan
- ALU, rd=5, result 0xDEADBEEF → one cycle later `WB`=1, `Rd`=5, `reg_s`=0xDEADBEEF; the following cycle `Rd`=0, `reg_s`=0.
- LOAD BYTE signed, addr 0x...1, `dm_rdata`=0x1280_3456 returned 3 cycles later → `m_ready` low for 3 cycles; write 0xFFFFFF80.
- LOAD HALF unsigned, addr 0x...2, `dm_rdata`=0x1234_ABCD → `reg_s`=0x0000ABCD. Then the same request signed → 0xFFFFABCD.
- ALU with rd=0, value 0x55 → `WB` never asserts; `Rd` and `reg_s` stay 0.
- LOAD with no response, `TIMEOUT_CYCLES`=4 → `load_err`=1 and `m_ready`=1 after 4 cycles, no write. Assert `rst_n` mid-WAIT on a second load → outputs return to reset values asynchronously.
- With `DLX_WB_LINK_EN`: LINK, pc=0x100 → `Rd`=31, `reg_s`=0x108. Without it: `Rd`=`m_rd`, `reg_s`=`m_result`.
